// File: rtl/grl_spike_encoder_pkg.sv
// grl_pkg: shared types and constants for the GRL spike encoder.
//   GRL_NUM_LINES / GRL_TIME_W / GRL_RST_LEN : default geometry
//   NO_SPIKE                                 : all-ones time, line never falls
//   enc_state_t                              : IDLE / RUN / RESET sequencing
//   spike_time_t                             : one line's spike time
package grl_pkg;

   localparam int GRL_NUM_LINES = 4;
   localparam int GRL_TIME_W    = 3;
   localparam int GRL_RST_LEN   = 4;

   typedef logic [GRL_TIME_W-1:0] spike_time_t;

   localparam spike_time_t NO_SPIKE = {GRL_TIME_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      RESET = 2'd2
   } enc_state_t;

endpackage

// File: rtl/grl_spike_encoder_if.sv
// grl_spike_encoder_if: time-vector handshake into the spike encoder.
//   in_valid : source has a time vector on in_times
//   in_ready : encoder can accept a vector this cycle
//   in_times : packed [0:NUM_LINES-1][TIME_W-1:0] per-line spike times
// Modports: master (feature buffer side), slave (encoder side).
interface grl_spike_encoder_if
   import grl_pkg::*;
#(
   parameter int NUM_LINES = GRL_NUM_LINES,
   parameter int TIME_W    = GRL_TIME_W
);

   logic                                  in_valid;
   logic                                  in_ready;
   logic [0:NUM_LINES-1][TIME_W-1:0]      in_times;

   modport master (output in_valid, output in_times, input in_ready);
   modport slave  (input in_valid, input in_times, output in_ready);

endinterface

// File: rtl/grl_spike_encoder_line_driver.sv
// grl_line_driver: one GRL output line.
//   clk, rst_n : clock, async active-low reset (line high, time discarded)
//   load       : vector accepted this edge; load_time is latched
//   load_time  : spike time for this line
//   step       : run window advancing to step_time on this edge
//   step_time  : run counter value visible in the next cycle
//   clear      : run window ends; line returns high for the gamma reset
//   line_out   : registered GRL line, 1 = no event yet
// The output is registered from the *next* counter value so that a line
// with time t is low exactly in run cycle t (time 0 falls together with
// gamma_start).
module grl_line_driver
   import grl_pkg::*;
#(
   parameter int TIME_W = GRL_TIME_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [TIME_W-1:0] load_time,
   input  logic              step,
   input  logic [TIME_W:0]   step_time,
   input  logic              clear,
   output logic              line_out
);

   localparam logic [TIME_W-1:0] NO_T = {TIME_W{1'b1}};

   logic [TIME_W-1:0] time_r;
   logic              line_r;

   // Latch the time and drive the monotonic falling edge of the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_r <= NO_T;
         line_r <= 1'b1;
      end else if (load) begin
         time_r <= load_time;
         line_r <= (load_time != {TIME_W{1'b0}});
      end else if (clear) begin
         time_r <= time_r;
         line_r <= 1'b1;
      end else if (step && (time_r != NO_T) && ({1'b0, time_r} == step_time)) begin
         time_r <= time_r;
         line_r <= 1'b0;
      end else begin
         time_r <= time_r;
         line_r <= line_r;
      end
   end

   assign line_out = line_r;

endmodule

// File: rtl/grl_spike_encoder.sv
// grl_spike_encoder: converts per-line binary spike times into GRL spike
// trains (idle high, 1->0 at the encoded time) and owns gamma-cycle timing.
//   clk, rst_n   : clock, async active-low reset
//   in_bus       : grl_spike_encoder_if.slave (in_valid / in_ready / in_times)
//   spikes_out   : [0:NUM_LINES-1] GRL lines, 1 = no event yet
//   gamma_start  : one-cycle pulse marking time 0 of the run window
//   busy         : high in RUN or RESET
// Optional (macro GRL_SPIKE_ENC_DONE_EN):
//   gamma_done   : one-cycle pulse in the final RESET cycle
//   first_time   : minimum latched time, all-ones if no line spikes
// Gamma period accept-to-accept is 1 + 2^TIME_W + RST_LEN cycles.
module grl_spike_encoder
   import grl_pkg::*;
#(
   parameter int NUM_LINES = GRL_NUM_LINES,
   parameter int TIME_W    = GRL_TIME_W,
   parameter int RST_LEN   = GRL_RST_LEN
) (
   input  logic                 clk,
   input  logic                 rst_n,
   grl_spike_encoder_if.slave   in_bus,
   output logic [0:NUM_LINES-1] spikes_out,
   output logic                 gamma_start,
   output logic                 busy
`ifdef GRL_SPIKE_ENC_DONE_EN
   ,output logic                gamma_done
   ,output logic [TIME_W-1:0]   first_time
`endif
);

   localparam int                CNT_W    = TIME_W + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << TIME_W) - 1);
   localparam int                RST_CW   = $clog2(RST_LEN + 1);
   localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(RST_LEN - 1);

   enc_state_t        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [RST_CW-1:0] rst_cnt_r;
   logic              in_ready_r;
   logic              gamma_start_r;
   logic              busy_r;

   logic              accept_s;
   logic              run_end_s;
   logic              step_s;
   logic [CNT_W-1:0]  step_time_s;

   // Handshake and run-window strobes shared by the FSM and line drivers.
   always_comb begin
      accept_s    = in_bus.in_valid && in_ready_r && (state_r == IDLE);
      run_end_s   = (state_r == RUN) && (cnt_r == CNT_LAST);
      step_s      = (state_r == RUN) && (cnt_r != CNT_LAST);
      step_time_s = cnt_r + CNT_W'(1);
   end

   // Gamma-cycle sequencer with registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         cnt_r         <= {CNT_W{1'b0}};
         rst_cnt_r     <= {RST_CW{1'b0}};
         in_ready_r    <= 1'b1;
         gamma_start_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         gamma_start_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r       <= RUN;
                  cnt_r         <= {CNT_W{1'b0}};
                  in_ready_r    <= 1'b0;
                  busy_r        <= 1'b1;
                  gamma_start_r <= 1'b1;
               end else begin
                  in_ready_r    <= 1'b1;
                  busy_r        <= 1'b0;
               end
            end
            RUN: begin
               if (cnt_r == CNT_LAST) begin
                  state_r   <= RESET;
                  rst_cnt_r <= {RST_CW{1'b0}};
               end else begin
                  cnt_r     <= cnt_r + CNT_W'(1);
               end
            end
            RESET: begin
               if (rst_cnt_r == RST_LAST) begin
                  state_r    <= IDLE;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
               end else begin
                  rst_cnt_r  <= rst_cnt_r + RST_CW'(1);
               end
            end
            default: begin
               state_r    <= IDLE;
               in_ready_r <= 1'b1;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign in_bus.in_ready = in_ready_r;
   assign gamma_start     = gamma_start_r;
   assign busy            = busy_r;

   for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
      grl_line_driver #(
         .TIME_W    (TIME_W)
      ) u_line (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (accept_s),
         .load_time (in_bus.in_times[i]),
         .step      (step_s),
         .step_time (step_time_s),
         .clear     (run_end_s),
         .line_out  (spikes_out[i])
      );
   end

`ifdef GRL_SPIKE_ENC_DONE_EN
   logic              gamma_done_r;
   logic              done_next_s;
   logic [TIME_W-1:0] first_time_r;
   logic [TIME_W-1:0] min_time_s;

   // Minimum incoming time and "next cycle is the last RESET cycle" flag.
   always_comb begin
      min_time_s = {TIME_W{1'b1}};
      for (int i = 0; i < NUM_LINES; i++) begin
         min_time_s = (in_bus.in_times[i] < min_time_s) ? in_bus.in_times[i] : min_time_s;
      end
      if (run_end_s) begin
         done_next_s = (RST_LEN == 1);
      end else if ((state_r == RESET) && (rst_cnt_r != RST_LAST)) begin
         done_next_s = ((rst_cnt_r + RST_CW'(1)) == RST_LAST);
      end else begin
         done_next_s = 1'b0;
      end
   end

   // Register gamma_done and the earliest spike time of the accepted vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gamma_done_r <= 1'b0;
         first_time_r <= {TIME_W{1'b1}};
      end else begin
         gamma_done_r <= done_next_s;
         if (accept_s) begin
            first_time_r <= min_time_s;
         end else begin
            first_time_r <= first_time_r;
         end
      end
   end

   assign gamma_done = gamma_done_r;
   assign first_time = first_time_r;
`endif

endmodule

// File: doc/grl_spike_encoder.md
Name: grl_spike_encoder

Overview:
- Clocked transmitter that converts per-line binary spike times into GRL spike trains.
- A spike is a 1->0 transition: each line idles high and falls at its encoded time within a gamma cycle.
- Produces the input_spikes bundle consumed by the neuron_snl_grl / column datapath.
- Sits between the binary input/feature buffer and the first TNN layer, and owns gamma-cycle timing for that layer.

Parameters:
- NUM_LINES, 4, number of spike lines driven.
- TIME_W, 3, width of each spike time. Valid times 0..2^TIME_W-2; all-ones means no spike.
- RST_LEN, 4, number of reset-phase cycles after the run window during which all lines are held high.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_times is valid.
- in_ready  output  1  encoder can accept a new time vector.
- in_times  input  NUM_LINES x TIME_W  packed [0:NUM_LINES-1][TIME_W-1:0]; per-line spike time.
- spikes_out  output  NUM_LINES  packed [0:NUM_LINES-1]; GRL lines, 1 = no event yet.
- gamma_start  output  1  one-cycle pulse marking time 0 of the run window.
- busy  output  1  high in RUN or RESET.

Behaviour:
- Clock and reset are decided: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, sync release):
  - state=IDLE, counter=0, latched times all-ones.
  - spikes_out='1, in_ready=1, gamma_start=0, busy=0.
- States: IDLE, RUN, RESET.
- IDLE:
  - in_ready=1, spikes_out='1.
  - Accept when in_valid && in_ready at edge E0: latch in_times, counter<=0, go to RUN.
  - in_valid while not ready is ignored; the source must hold it.
- RUN:
  - counter counts 0..2^TIME_W-1, one step per cycle.
  - gamma_start=1 for exactly the first RUN cycle (after E0).
  - All outputs are registered.
  - spikes_out[i] falls at edge E0+1+t_i and stays 0 until RESET.
  - t_i = 0 falls at E0+1, together with gamma_start rising.
  - t_i = all-ones never falls.
  - Several lines with equal t fall on the same edge.
  - Lines never return to 1 inside RUN (monotonic; no glitches).
  - After counter = 2^TIME_W-1, go to RESET.
- RESET:
  - spikes_out='1 for RST_LEN cycles (the rising edge is the GRL reset, not an event).
  - Then go to IDLE; in_ready rises the cycle after the last RESET cycle.
- Gamma period is 1 + 2^TIME_W + RST_LEN cycles accept-to-accept, minimum with back-to-back valid.
  - With defaults: 1 + 8 + 4 = 13.
- in_ready=0 and busy=1 throughout RUN and RESET.
- Counter width is TIME_W+1 internally; no wrap inside RUN. The RESET count uses a separate counter sized for RST_LEN.
- rst_n asserted mid-RUN: all lines return to 1 immediately (async), no pulse emitted, latched times discarded.
- in_times changing after acceptance has no effect.

Optional Feature:
- Macro GRL_SPIKE_ENC_DONE_EN.
- Defined:
  - Extra output gamma_done (1 bit), a one-cycle pulse in the final RESET cycle.
  - Extra output first_time (TIME_W bits): registered minimum latched t, valid from gamma_start; all-ones if no line spikes.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package grl_pkg:
  - TIME_W default.
  - NO_SPIKE constant (all-ones).
  - State enum enc_state_t {IDLE, RUN, RESET}.
  - typedef spike_time_t.
- Sub-module grl_line_driver, one per line:
  - Holds latched t plus a registered output.
  - Falls when run && counter==t, clears on rst_n or gamma reset.
  - Instantiated NUM_LINES times via generate.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> spikes_out=4'b1111, in_ready=1, busy=0, gamma_start=0.
- Single gamma: in_times={3,0,2,7} accepted at E0 ->
  - gamma_start at E0+1; line1 falls E0+1, line2 E0+3, line0 E0+4, line3 stays 1.
  - All lines high again at E0+9; in_ready high at E0+13.
- Ties and back-to-back:
  - in_times={1,1,1,1} then {6,5,4,0} with in_valid held -> all four lines fall on the same edge.
  - Second vector accepted exactly 13 cycles after the first.
- Backpressure: pulse in_valid with {2,2,2,2} during RUN -> ignored; no second gamma_start, in_ready stays 0.
- Mid-op reset: assert rst_n two cycles after gamma_start with {0,5,5,5} ->
  - line0 returns to 1 asynchronously, no further falls.
  - IDLE outputs after release.
- With GRL_SPIKE_ENC_DONE_EN: {4,6,5,7} -> first_time=4, gamma_done pulses once at E0+12; with {7,7,7,7} -> first_time=7.
